// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button edge detection, run/pause/lap FSM,
// centisecond prescaler and cascaded BCD MM:SS.cc counters with lap freeze.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1_000_000,
  parameter int CNT_W    = 20
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_cs,
  output logic       running,
  output logic       lap_hold
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_LAP       = 3'd2,
    S_PAUSE     = 3'd3,
    S_PAUSE_LAP = 3'd4
  } state_t;

  // Button bit order: [0] start_stop, [1] lap, [2] clear.
  logic [2:0]       btn_cur_q, btn_cur_d;
  logic [2:0]       btn_old_q, btn_old_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  // Time packing: {min10, min1, sec10, sec1, cs10, cs1}, one BCD digit each.
  logic [23:0]      cnt_q, cnt_d;
  logic [23:0]      freeze_q, freeze_d;
  logic [23:0]      disp_q, disp_d;
  logic             running_q, running_d;
  logic             lap_hold_q, lap_hold_d;

  logic [2:0] btn_edge;
  logic       ev_ss, ev_lap, ev_clr;
  logic       clr_cnt, take_lap, tick;

  // Add one centisecond; each digit wraps at its own limit (min/sec tens at 5).
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  d;
    logic [3:0]  lim;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d   = r[i*4 +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (d >= lim) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  // Rising-edge flags; one flag per press regardless of hold length.
  always_comb begin
    btn_cur_d = {btn_clear, btn_lap, btn_start_stop};
    btn_old_d = btn_cur_q;
    btn_edge  = btn_cur_q & ~btn_old_q;
    ev_clr    = btn_edge[2];
    ev_ss     = btn_edge[0] & ~btn_edge[2];
    ev_lap    = btn_edge[1] & ~btn_edge[2] & ~btn_edge[0];
  end

  // Next-state logic; clear only acts from the two pause states.
  always_comb begin
    state_d  = state_q;
    clr_cnt  = 1'b0;
    take_lap = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (ev_ss) begin
          state_d = S_PAUSE;
        end else if (ev_lap) begin
          state_d  = S_LAP;
          take_lap = 1'b1;
        end
      end
      S_LAP: begin
        if (ev_ss)       state_d = S_PAUSE_LAP;
        else if (ev_lap) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ev_clr) begin
          state_d = S_IDLE;
          clr_cnt = 1'b1;
        end else if (ev_ss) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE_LAP: begin
        if (ev_clr) begin
          state_d = S_IDLE;
          clr_cnt = 1'b1;
        end else if (ev_ss) begin
          state_d = S_LAP;
        end else if (ev_lap) begin
          state_d = S_PAUSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler, time counters, freeze register and registered display values.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clr_cnt || state_q == S_IDLE) begin
      presc_d = '0;
    end else if (state_q == S_RUN || state_q == S_LAP) begin
      if (presc_q == CNT_W'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + CNT_W'(1);
      end
    end

    cnt_d = cnt_q;
    if (clr_cnt)   cnt_d = '0;
    else if (tick) cnt_d = bcd_inc(cnt_q);

    freeze_d = freeze_q;
    if (clr_cnt)       freeze_d = '0;
    else if (take_lap) freeze_d = cnt_q;

    running_d  = (state_d == S_RUN) || (state_d == S_LAP);
    lap_hold_d = (state_d == S_LAP) || (state_d == S_PAUSE_LAP);

    // Clearing blanks the display immediately instead of showing the old count.
    if (clr_cnt)         disp_d = '0;
    else if (lap_hold_d) disp_d = freeze_d;
    else                 disp_d = cnt_q;
  end

  // State register with synchronous reset; a reset also drops pending edges.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      btn_cur_q  <= '0;
      btn_old_q  <= '0;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      freeze_q   <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      btn_cur_q  <= btn_cur_d;
      btn_old_q  <= btn_old_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      freeze_q   <= freeze_d;
      disp_q     <= disp_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign disp_min = disp_q[23:16];
  assign disp_sec = disp_q[15:8];
  assign disp_cs  = disp_q[7:0];
  assign running  = running_q;
  assign lap_hold = lap_hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4 (one centisecond per 4 clocks).
module tb_stopwatch_ctrl;

  logic       clk;
  logic       reset_p;
  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_clear;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] disp_cs;
  logic       running;
  logic       lap_hold;

  int checks;
  int failures;

  stopwatch_ctrl #(.TICK_DIV(4), .CNT_W(20)) dut (
    .clk            (clk),
    .reset_p        (reset_p),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .disp_min       (disp_min),
    .disp_sec       (disp_sec),
    .disp_cs        (disp_cs),
    .running        (running),
    .lap_hold       (lap_hold)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press buttons for two edges; the FSM acts on the second edge.
  task automatic press(input logic ss, input logic lp, input logic cl);
    btn_start_stop = ss;
    btn_lap        = lp;
    btn_clear      = cl;
    @(posedge clk);
    @(posedge clk);
    #1;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] m, input logic [7:0] s,
                          input logic [7:0] c);
    chk({tag, "_min"}, disp_min, m);
    chk({tag, "_sec"}, disp_sec, s);
    chk({tag, "_cs"},  disp_cs,  c);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset_p        = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;

    // Reset state
    cyc(3);
    reset_p = 1'b0;
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk("reset_running", {7'd0, running}, 8'h00);
    chk("reset_lap_hold", {7'd0, lap_hold}, 8'h00);

    // Start: RUN entered on the second edge of the press
    press(1'b1, 1'b0, 1'b0);
    chk("start_running", {7'd0, running}, 8'h01);
    chk("start_lap_hold", {7'd0, lap_hold}, 8'h00);

    // 401 edges after RUN entry the display shows 00:01.00
    cyc(401);
    chk_time("one_sec", 8'h00, 8'h01, 8'h00);
    cyc(4);
    chk("cs_plus4", disp_cs, 8'h01);
    cyc(3);
    chk("cs_plus7", disp_cs, 8'h01);
    cyc(1);
    chk("cs_plus8", disp_cs, 8'h02);

    // Seconds carry into minutes
    cyc(23591);
    chk_time("pre_min_carry", 8'h00, 8'h59, 8'h99);
    cyc(1);
    chk_time("min_carry", 8'h01, 8'h00, 8'h00);

    // Pause holds the count
    press(1'b1, 1'b0, 1'b0);
    chk("pause_running", {7'd0, running}, 8'h00);
    cyc(10);
    chk_time("pause_hold", 8'h01, 8'h00, 8'h00);

    // Clear from PAUSE
    press(1'b0, 1'b0, 1'b1);
    chk_time("clear_pause", 8'h00, 8'h00, 8'h00);
    chk("clear_pause_running", {7'd0, running}, 8'h00);

    // Lap at 00:00.37
    press(1'b1, 1'b0, 1'b0);
    cyc(148);
    chk("pre_lap_cs", disp_cs, 8'h36);
    press(1'b0, 1'b1, 1'b0);
    chk("lap_hold_on", {7'd0, lap_hold}, 8'h01);
    chk("lap_running", {7'd0, running}, 8'h01);
    chk_time("lap_frozen", 8'h00, 8'h00, 8'h37);
    cyc(40);
    chk("lap_still_frozen", disp_cs, 8'h37);
    press(1'b0, 1'b1, 1'b0);
    chk("unlap_hold", {7'd0, lap_hold}, 8'h00);
    chk("unlap_live_cs", disp_cs, 8'h47);

    // Pause two prescaler counts into a period, resume keeps the fraction
    press(1'b1, 1'b0, 1'b0);
    chk("frac_pause_running", {7'd0, running}, 8'h00);
    chk("frac_pause_cs", disp_cs, 8'h48);
    cyc(100);
    chk("frac_pause_hold", disp_cs, 8'h48);
    press(1'b1, 1'b0, 1'b0);
    chk("resume_running", {7'd0, running}, 8'h01);
    cyc(2);
    chk("resume_before_tick", disp_cs, 8'h48);
    cyc(1);
    chk("resume_tick_early", disp_cs, 8'h49);
    cyc(4);
    chk("resume_next_tick", disp_cs, 8'h50);

    // Clear while running is ignored
    press(1'b0, 1'b0, 1'b1);
    cyc(9);
    chk("clear_run_running", {7'd0, running}, 8'h01);
    chk("clear_run_cs", disp_cs, 8'h52);

    // LAP -> PAUSE_LAP -> clear -> IDLE
    press(1'b0, 1'b1, 1'b0);
    chk("lap2_cs", disp_cs, 8'h53);
    chk("lap2_hold", {7'd0, lap_hold}, 8'h01);
    press(1'b1, 1'b0, 1'b0);
    chk("pause_lap_running", {7'd0, running}, 8'h00);
    chk("pause_lap_hold", {7'd0, lap_hold}, 8'h01);
    chk("pause_lap_cs", disp_cs, 8'h53);
    press(1'b0, 1'b0, 1'b1);
    chk_time("clear_pause_lap", 8'h00, 8'h00, 8'h00);
    chk("clear_pause_lap_hold", {7'd0, lap_hold}, 8'h00);
    chk("clear_pause_lap_running", {7'd0, running}, 8'h00);

    // Clear and start_stop together from PAUSE: clear wins
    press(1'b1, 1'b0, 1'b0);
    cyc(20);
    press(1'b1, 1'b0, 1'b0);
    chk("pause2_cs", disp_cs, 8'h05);
    chk("pause2_running", {7'd0, running}, 8'h00);
    press(1'b1, 1'b0, 1'b1);
    chk("both_running", {7'd0, running}, 8'h00);
    chk("both_cs", disp_cs, 8'h00);
    cyc(10);
    chk("both_idle_running", {7'd0, running}, 8'h00);
    chk("both_idle_cs", disp_cs, 8'h00);

    // Long hold of start_stop toggles exactly once
    btn_start_stop = 1'b1;
    cyc(50);
    btn_start_stop = 1'b0;
    cyc(2);
    chk("hold_running", {7'd0, running}, 8'h01);
    chk("hold_cs", disp_cs, 8'h12);

    // Reset while in LAP
    press(1'b0, 1'b1, 1'b0);
    chk("lap3_hold", {7'd0, lap_hold}, 8'h01);
    chk("lap3_cs", disp_cs, 8'h12);
    reset_p = 1'b1;
    cyc(1);
    chk_time("mid_reset", 8'h00, 8'h00, 8'h00);
    chk("mid_reset_running", {7'd0, running}, 8'h00);
    chk("mid_reset_lap_hold", {7'd0, lap_hold}, 8'h00);
    reset_p = 1'b0;
    cyc(10);
    chk("post_reset_running", {7'd0, running}, 8'h00);
    chk("post_reset_cs", disp_cs, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
